// File: rtl/binary_one_hot_codec.sv
// ============================================================================
// binary_one_hot_codec: binary <-> one-hot codec behind a 2-entry skid buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module binary_one_hot_codec #(
  parameter int BIN_W     = 4,
  parameter int ONE_HOT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mode,
  input  logic [BIN_W-1:0]     bin,
  input  logic [ONE_HOT_W-1:0] one_hot,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIN_W-1:0]     out_bin,
  output logic [ONE_HOT_W-1:0] out_one_hot,
  output logic                 out_err,
  input  logic                 err_clr,
  output logic [7:0]           err_cnt
);

  logic [BIN_W-1:0]     w_res_bin;
  logic [ONE_HOT_W-1:0] w_res_oh;
  logic                 w_res_err;
  logic                 w_found;
  logic                 w_multi;
  logic                 w_accept;
  logic                 w_err_acc;

  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [BIN_W-1:0]     r_out_bin;
  logic [ONE_HOT_W-1:0] r_out_oh;
  logic                 r_out_err;
  logic                 r_skid_valid;
  logic [BIN_W-1:0]     r_skid_bin;
  logic [ONE_HOT_W-1:0] r_skid_oh;
  logic                 r_skid_err;
  logic [7:0]           r_err_cnt;

  always_comb begin
    w_res_bin = '0;
    w_res_oh  = '0;
    w_res_err = 1'b0;
    w_found   = 1'b0;
    w_multi   = 1'b0;
    if (!mode) begin
      // Any bin without a matching one-hot lane is out of range.
      w_res_bin = bin;
      w_res_err = 1'b1;
      for (int k = 0; k < ONE_HOT_W; k++) begin
        if (bin == BIN_W'(k)) begin
          w_res_oh[k] = 1'b1;
          w_res_err   = 1'b0;
        end
      end
    end else begin
      for (int k = 0; k < ONE_HOT_W; k++) begin
        if (one_hot[k]) begin
          if (!w_found) begin
            w_res_bin = BIN_W'(k);
            w_found   = 1'b1;
          end else begin
            w_multi = 1'b1;
          end
        end
      end
      w_res_oh  = w_found ? one_hot : '0;
      w_res_err = !w_found || w_multi;
    end
  end

  assign w_accept  = in_valid && r_in_ready;
  assign w_err_acc = w_accept && w_res_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_bin    <= '0;
      r_out_oh     <= '0;
      r_out_err    <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_bin   <= '0;
      r_skid_oh    <= '0;
      r_skid_err   <= 1'b0;
      r_err_cnt    <= 8'd0;
    end else begin
      r_in_ready <= 1'b1;
      if (r_skid_valid) begin
        // Skid full implies output full, so out_ready alone is the handshake.
        r_in_ready <= out_ready;
        if (out_ready) begin
          r_out_bin    <= r_skid_bin;
          r_out_oh     <= r_skid_oh;
          r_out_err    <= r_skid_err;
          r_skid_valid <= 1'b0;
        end
      end else if (w_accept) begin
        if (!r_out_valid || out_ready) begin
          r_out_valid <= 1'b1;
          r_out_bin   <= w_res_bin;
          r_out_oh    <= w_res_oh;
          r_out_err   <= w_res_err;
        end else begin
          r_skid_valid <= 1'b1;
          r_skid_bin   <= w_res_bin;
          r_skid_oh    <= w_res_oh;
          r_skid_err   <= w_res_err;
          r_in_ready   <= 1'b0;
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (err_clr) begin
        r_err_cnt <= {7'd0, w_err_acc};
      end else if (w_err_acc && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_bin     = r_out_bin;
  assign out_one_hot = r_out_oh;
  assign out_err     = r_out_err;
  assign err_cnt     = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_binary_one_hot_codec.sv
// ============================================================================
// tb_binary_one_hot_codec: directed and random checks of the codec (16 and 12 lanes).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_binary_one_hot_codec;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        mode;
  logic [3:0]  bin;
  logic [15:0] one_hot;
  logic [11:0] one_hot12;
  logic        out_ready;
  logic        err_clr;

  logic        in_ready, out_valid, out_err;
  logic [3:0]  out_bin;
  logic [15:0] out_one_hot;
  logic [7:0]  err_cnt;

  logic        in_ready12, out_valid12, out_err12;
  logic [3:0]  out_bin12;
  logic [11:0] out_one_hot12;
  logic [7:0]  err_cnt12;

  int errors = 0;
  int checks = 0;

  assign one_hot12 = one_hot[11:0];

  binary_one_hot_codec #(.BIN_W(4), .ONE_HOT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .bin(bin), .one_hot(one_hot), .out_valid(out_valid),
    .out_ready(out_ready), .out_bin(out_bin), .out_one_hot(out_one_hot),
    .out_err(out_err), .err_clr(err_clr), .err_cnt(err_cnt)
  );

  binary_one_hot_codec #(.BIN_W(4), .ONE_HOT_W(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready12),
    .mode(mode), .bin(bin), .one_hot(one_hot12), .out_valid(out_valid12),
    .out_ready(out_ready), .out_bin(out_bin12), .out_one_hot(out_one_hot12),
    .out_err(out_err12), .err_clr(err_clr), .err_cnt(err_cnt12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic m, input logic [3:0] b, input logic [15:0] oh);
    mode = m; bin = b; one_hot = oh; in_valid = 1'b1;
  endtask

  // Reference result {bin, one_hot, err} for the 16-lane instance.
  function automatic logic [20:0] model(input logic m, input logic [3:0] b, input logic [15:0] oh);
    logic [3:0] idx;
    int         n;
    if (!m) return {b, 16'h0001 << b, 1'b0};
    idx = 4'd0;
    n   = $countones(oh);
    for (int k = 15; k >= 0; k--) if (oh[k]) idx = 4'(k);
    return {idx, (n == 0) ? 16'h0000 : oh, (n != 1)};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; bin = 4'd0; one_hot = 16'h0;
    out_ready = 1'b0; err_clr = 1'b0;
    #2;
    checks++;
    if ({out_valid, in_ready, out_err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got v/r/e=%b%b%b want 000", out_valid, in_ready, out_err);
    end
    checks++;
    if (err_cnt !== 8'd0 || out_one_hot !== 16'h0 || out_bin !== 4'd0) begin
      errors++; $display("FAIL reset_data: got cnt=%0d oh=%h bin=%0d want 0/0/0", err_cnt, out_one_hot, out_bin);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_encode_sweep;
    logic [15:0] exp_oh;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'(i), 16'h0);
      @(negedge clk);
      exp_oh = 16'h0001 << i;
      checks++;
      if (out_valid !== 1'b1 || out_one_hot !== exp_oh || out_bin !== 4'(i) || out_err !== 1'b0) begin
        errors++; $display("FAIL enc_sweep bin=%0d: got v=%b oh=%h b=%0d e=%b want 1/%h/%0d/0",
                           i, out_valid, out_one_hot, out_bin, out_err, exp_oh, i);
      end
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL enc_ready bin=%0d: got %b want 1", i, in_ready);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (err_cnt !== 8'd0) begin
      errors++; $display("FAIL enc_errcnt: got %0d want 0", err_cnt);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL enc_drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_errors;
    err_clr = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    err_clr = 1'b0; out_ready = 1'b1;
    drive(1'b0, 4'd13, 16'h0);
    @(negedge clk);
    checks++;
    if (out_valid12 !== 1'b1 || out_one_hot12 !== 12'h000 || out_err12 !== 1'b1) begin
      errors++; $display("FAIL err_enc13: got v=%b oh=%h e=%b want 1/000/1", out_valid12, out_one_hot12, out_err12);
    end
    drive(1'b1, 4'd0, 16'h0000);
    @(negedge clk);
    checks++;
    if (out_bin12 !== 4'd0 || out_one_hot12 !== 12'h000 || out_err12 !== 1'b1) begin
      errors++; $display("FAIL err_dec_zero: got b=%0d oh=%h e=%b want 0/000/1", out_bin12, out_one_hot12, out_err12);
    end
    drive(1'b1, 4'd0, 16'h00A0);
    @(negedge clk);
    checks++;
    if (out_bin12 !== 4'd5 || out_one_hot12 !== 12'h0A0 || out_err12 !== 1'b1) begin
      errors++; $display("FAIL err_dec_multi: got b=%0d oh=%h e=%b want 5/0a0/1", out_bin12, out_one_hot12, out_err12);
    end
    drive(1'b1, 4'd0, 16'h0800);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_bin12 !== 4'd11 || out_one_hot12 !== 12'h800 || out_err12 !== 1'b0) begin
      errors++; $display("FAIL dec_top: got b=%0d oh=%h e=%b want 11/800/0", out_bin12, out_one_hot12, out_err12);
    end
    checks++;
    if (err_cnt12 !== 8'd3) begin
      errors++; $display("FAIL err_cnt12: got %0d want 3", err_cnt12);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    drive(1'b0, 4'd3, 16'h0);   // A
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_one_hot !== 16'h0008 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_a: got v=%b oh=%h r=%b want 1/0008/1", out_valid, out_one_hot, in_ready);
    end
    drive(1'b0, 4'd7, 16'h0);   // B
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_one_hot !== 16'h0008) begin
      errors++; $display("FAIL bp_stall: got r=%b oh=%h want 0/0008", in_ready, out_one_hot);
    end
    drive(1'b0, 4'd9, 16'h0);   // C, must be ignored
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_one_hot !== 16'h0008) begin
      errors++; $display("FAIL bp_hold: got r=%b v=%b oh=%h want 0/1/0008", in_ready, out_valid, out_one_hot);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_one_hot !== 16'h0080 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_b: got v=%b oh=%h r=%b want 1/0080/1", out_valid, out_one_hot, in_ready);
    end
    drive(1'b0, 4'd9, 16'h0);   // C re-sent
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_one_hot !== 16'h0200) begin
      errors++; $display("FAIL bp_c: got v=%b oh=%h want 1/0200", out_valid, out_one_hot);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_dup: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_saturation;
    err_clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, 4'd0, 16'h0000);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (err_cnt !== 8'd255) begin
      errors++; $display("FAIL sat_255: got %0d want 255", err_cnt);
    end
    err_clr = 1'b1;
    drive(1'b1, 4'd0, 16'h0000);
    @(negedge clk);
    err_clr = 1'b0; in_valid = 1'b0;
    checks++;
    if (err_cnt !== 8'd1) begin
      errors++; $display("FAIL clr_with_err: got %0d want 1", err_cnt);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (err_cnt !== 8'd0) begin
      errors++; $display("FAIL clr_plain: got %0d want 0", err_cnt);
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    drive(1'b0, 4'd2, 16'h0);
    @(negedge clk);
    drive(1'b0, 4'd6, 16'h0);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL rst_mid_full: got r=%b v=%b want 0/1", in_ready, out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_one_hot !== 16'h0) begin
      errors++; $display("FAIL rst_mid_async: got v=%b r=%b oh=%h want 0/0/0000", out_valid, in_ready, out_one_hot);
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_empty: got v=%b r=%b want 0/1", out_valid, in_ready);
    end
    drive(1'b0, 4'd5, 16'h0);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_one_hot !== 16'h0020) begin
      errors++; $display("FAIL rst_mid_first: got v=%b oh=%h want 1/0020", out_valid, out_one_hot);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_skid: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_random;
    logic [20:0] q[$];
    logic [20:0] res;
    int          mcnt;
    bit          fire_in, fire_out;
    err_clr = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    err_clr = 1'b0;
    mcnt = 0;
    for (int c = 0; c < 400; c++) begin
      checks++;
      if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2) || err_cnt !== 8'(mcnt)) begin
        errors++; $display("FAIL rnd_ctrl cyc=%0d: got v=%b r=%b cnt=%0d want %b/%b/%0d",
                           c, out_valid, in_ready, err_cnt, q.size() != 0, q.size() < 2, mcnt);
      end
      if (q.size() != 0) begin
        checks++;
        if ({out_bin, out_one_hot, out_err} !== q[0]) begin
          errors++; $display("FAIL rnd_data cyc=%0d: got %h/%h/%b want %h/%h/%b", c,
                             out_bin, out_one_hot, out_err, q[0][20:17], q[0][16:1], q[0][0]);
        end
      end
      in_valid  = ($urandom_range(3) != 0);
      mode      = $urandom_range(1) == 1;
      bin       = 4'($urandom_range(15));
      case ($urandom_range(2))
        0:       one_hot = 16'h0001 << $urandom_range(15);
        1:       one_hot = 16'h0000;
        default: one_hot = 16'($urandom);
      endcase
      out_ready = ($urandom_range(2) != 0);
      err_clr   = ($urandom_range(31) == 0);
      res       = model(mode, bin, one_hot);
      fire_in   = in_valid && (q.size() < 2);
      fire_out  = out_ready && (q.size() != 0);
      if (fire_out) void'(q.pop_front());
      if (fire_in) q.push_back(res);
      if (err_clr) mcnt = (fire_in && res[0]) ? 1 : 0;
      else if (fire_in && res[0] && mcnt < 255) mcnt++;
      @(negedge clk);
    end
    in_valid = 1'b0; err_clr = 1'b0; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_encode_sweep();
    test_errors();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
